// File: rtl/reg_file_32x32_pkg.sv
// cpu_defs: shared datapath widths and named register indices used by the
// register file and by control.
package cpu_defs;
   localparam int REG_ADDR_W = 5;
   localparam int WORD_W     = 32;
   localparam int NUM_GPR    = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [WORD_W-1:0]     word_t;
endpackage

// File: rtl/reg_file_32x32_rf_read_port.sv
// rf_read_port: one combinational read port with zero-register masking,
// out-of-range masking and same-cycle write-back bypass.
module rf_read_port
   import cpu_defs::*;
#(
   parameter int DATA_W   = WORD_W,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int NUM_REGS = NUM_GPR
) (
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] word,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data
);
   logic in_range;
   always_comb begin
      in_range = addr != ADDR_W'(REG_ZERO) && 32'(addr) < NUM_REGS;
      // Masking comes first so r0 never picks up a bypassed write.
      data = (!rst_n || !in_range) ? '0 : (wr_en && wr_addr == addr) ? wr_data : word;
   end
endmodule

// File: rtl/reg_file_32x32.sv
// reg_file_32x32: integer register file, 2 async read ports with write-back
// bypass, 1 sync write port, r0 hardwired to zero.
module reg_file_32x32
   import cpu_defs::*;
#(
   parameter int DATA_W   = WORD_W,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int NUM_REGS = NUM_GPR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);
   localparam int IDX_W = $clog2(NUM_REGS);
   logic [DATA_W-1:0] regs_q [0:NUM_REGS-1];
   logic [DATA_W-1:0] regs_d [0:NUM_REGS-1];
   logic              wr_ok;
   always_comb begin
      wr_ok  = wr_addr != ADDR_W'(REG_ZERO) && 32'(wr_addr) < NUM_REGS;
      regs_d = regs_q;
      // An unknown wr_en takes the no-write path, keeping the array clean.
      if (wr_en && wr_ok) regs_d[wr_addr[IDX_W-1:0]] = wr_data;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) regs_q <= '{default: '0};
      else        regs_q <= regs_d;
   end
   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_port_a (
      .rst_n   (rst_n),
      .addr    (rd_addr_a),
      .word    (regs_q[rd_addr_a[IDX_W-1:0]]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data_a)
   );
   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_port_b (
      .rst_n   (rst_n),
      .addr    (rd_addr_b),
      .word    (regs_q[rd_addr_b[IDX_W-1:0]]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data_b)
   );
endmodule

// File: tb/tb_reg_file_32x32.sv
// tb_reg_file_32x32: directed scoreboard bench for the 32-entry register file
// and a 16-entry build sharing the same stimulus.
module tb_reg_file_32x32;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data_a, rd_data_b, rd16_a, rd16_b;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [32];
   logic [31:0] model16 [16];
   typedef struct {
      string       tag;
      int          port;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   reg_file_32x32 dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );
   reg_file_32x32 #(.NUM_REGS(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd16_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd16_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   function automatic logic [31:0] ref_rd(input logic [4:0] a, input int n);
      if (rst_n !== 1'b1 || a == 5'd0 || int'(a) >= n) return '0;
      if (wr_en === 1'b1 && wr_addr == a) return wr_data;
      return (n == 32) ? model[a] : model16[a[3:0]];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check all four read ports, then
   // advance the model to what the array should hold after the posedge.
   task automatic cyc(input string tag, input logic r, input logic e, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
      exp_t x;
      logic [31:0] got;
      @(negedge clk);
      rst_n = r; wr_en = e; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
      sb.push_back('{tag, 0, ref_rd(ra, 32)});
      sb.push_back('{tag, 1, ref_rd(rb, 32)});
      sb.push_back('{tag, 2, ref_rd(ra, 16)});
      sb.push_back('{tag, 3, ref_rd(rb, 16)});
      #2;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         got = (x.port == 0) ? rd_data_a : (x.port == 1) ? rd_data_b : (x.port == 2) ? rd16_a : rd16_b;
         checks++;
         assert (got === x.exp) else begin
            errors++;
            $error("FAIL %s port%0d got=%h exp=%h", x.tag, x.port, got, x.exp);
         end
      end
      if (r !== 1'b1) begin
         foreach (model[i]) model[i] = '0;
         foreach (model16[i]) model16[i] = '0;
      end else if (e === 1'b1 && wa != 5'd0) begin
         model[wa] = wd;
         if (wa < 5'd16) model16[wa[3:0]] = wd;
      end
   endtask

   initial begin
      foreach (model[i]) model[i] = '0;
      foreach (model16[i]) model16[i] = '0;
      cyc("init_rst", 0, 0, 0, 0, 5'd3, 5'd9);
      for (int i = 1; i < 32; i++) cyc("preload", 1, 1, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(i));
      cyc("pre_rst_rd", 1, 0, 0, 0, 5'd1, 5'd31);
      chk("preload_r31", rd_data_b, 32'hFFFF_FFFF);
      cyc("in_rst", 0, 0, 0, 0, 5'd5, 5'd31);
      chk("in_rst_a", rd_data_a, 32'h0);
      for (int i = 1; i < 32; i++) cyc("post_rst", 1, 0, 0, 0, 5'(i), 5'(32 - i));
      chk("post_rst_r1", rd_data_b, 32'h0);
      cyc("xwr", 1, 1'bx, 5'd4, 32'hBAD0_BAD0, 5'd1, 5'd2);
      cyc("xwr_rd", 1, 0, 0, 0, 5'd4, 5'd4);
      chk("xwr_r4", rd_data_a, 32'h0);
      cyc("wr_r5", 1, 1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
      cyc("idle", 1, 0, 0, 0, 5'd0, 5'd0);
      cyc("rd_r5", 1, 0, 0, 0, 5'd5, 5'd5);
      chk("r5_a", rd_data_a, 32'hDEAD_BEEF);
      chk("r5_b", rd_data_b, 32'hDEAD_BEEF);
      cyc("wr_r0", 1, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
      chk("r0_same_cycle", rd_data_a, 32'h0);
      cyc("rd_r0", 1, 0, 0, 0, 5'd0, 5'd5);
      chk("r0_after", rd_data_a, 32'h0);
      cyc("wr_r7", 1, 1, 5'd7, 32'h1111, 5'd0, 5'd0);
      cyc("wr_r8", 1, 1, 5'd8, 32'h8888, 5'd7, 5'd0);
      cyc("bypass", 1, 1, 5'd7, 32'h2222, 5'd7, 5'd8);
      chk("bypass_a", rd_data_a, 32'h2222);
      chk("bypass_b", rd_data_b, 32'h8888);
      cyc("bypass_next", 1, 0, 5'd7, 32'h0, 5'd7, 5'd7);
      chk("bypass_next_a", rd_data_a, 32'h2222);
      cyc("rst_vs_wr", 0, 1, 5'd3, 32'hAAAA, 5'd3, 5'd3);
      cyc("rst_release", 1, 0, 0, 0, 5'd3, 5'd7);
      chk("r3_after_rst", rd_data_a, 32'h0);
      cyc("b2b_1", 1, 1, 5'd9, 32'h1, 5'd0, 5'd9);
      chk("b2b_1_b", rd_data_b, 32'h1);
      cyc("b2b_2", 1, 1, 5'd9, 32'h2, 5'd0, 5'd9);
      chk("b2b_2_b", rd_data_b, 32'h2);
      cyc("b2b_hold", 1, 0, 0, 0, 5'd9, 5'd9);
      chk("b2b_hold_b", rd_data_b, 32'h2);
      cyc("wr_r20", 1, 1, 5'd20, 32'h5555, 5'd20, 5'd20);
      chk("r20_16_bypass", rd16_a, 32'h0);
      cyc("rd_r20", 1, 0, 0, 0, 5'd20, 5'd4);
      chk("r20_32", rd_data_a, 32'h5555);
      chk("r20_16", rd16_a, 32'h0);
      cyc("wr_r15", 1, 1, 5'd15, 32'hF00D, 5'd0, 5'd0);
      cyc("rd_r15", 1, 0, 0, 0, 5'd15, 5'd15);
      chk("r15_16", rd16_b, 32'hF00D);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
